// File: rtl/uart_rx_unit.sv
`timescale 1ns/1ps
// UART receiver with built-in baud generator: 7/8 data bits, optional parity
// (odd/even/mark/space), 1 or 2 stop bits, parity and framing error flags.
module uart_rx_unit #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       baud_sel,
    input  logic [2:0] div_ratio,
    input  logic       data_size,
    input  logic       parity_en,
    input  logic [1:0] parity_mode,
    input  logic       stop_bit_size,
    output logic [7:0] data,
    output logic       err_crc,
    output logic       err_frame,
    output logic       ready,
    output logic       new_data
);
    localparam int CW = 24;
    localparam logic [CW-1:0] BASE_SLOW = CW'(CLK_HZ / 76800);
    localparam logic [CW-1:0] BASE_FAST = CW'(CLK_HZ / 460800);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_DONE
    } state_t;

    state_t        r_state;
    logic          r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0] r_baud_cnt, r_period;
    logic          r_data_size, r_parity_en, r_stop_bit_size;
    logic [1:0]    r_parity_mode;
    logic [7:0]    r_shift, r_data;
    logic [2:0]    r_bit_cnt;
    logic          r_par_err, r_frm_err;
    logic          r_err_crc, r_err_frame, r_ready, r_new_data;

    logic [CW-1:0] w_period_in;
    logic          w_fall, w_tick, w_last_bit, w_par_exp;
    logic [7:0]    w_word;

    assign w_period_in = (baud_sel ? BASE_FAST : BASE_SLOW) << div_ratio;
    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_tick      = (r_state != S_IDLE) && (r_baud_cnt == '0);
    // In 7-bit mode the word ends one position short of bit 0.
    assign w_word      = r_data_size ? r_shift : {1'b0, r_shift[7:1]};
    assign w_last_bit  = (r_bit_cnt == (r_data_size ? 3'd7 : 3'd6));

    always_comb begin
        w_par_exp = 1'b0;
        case (r_parity_mode)
            2'b11:   w_par_exp = ~^w_word;
            2'b10:   w_par_exp = ^w_word;
            2'b01:   w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Half-period preload puts the first tick in the middle of the start bit.
    always_ff @(posedge clk) begin
        if (rst)
            r_baud_cnt <= '0;
        else if (r_state == S_IDLE)
            r_baud_cnt <= w_fall ? (w_period_in >> 1) - CW'(1) : '0;
        else if (r_baud_cnt == '0)
            r_baud_cnt <= r_period - CW'(1);
        else
            r_baud_cnt <= r_baud_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_period        <= '0;
            r_data_size     <= 1'b0;
            r_parity_en     <= 1'b0;
            r_parity_mode   <= 2'b00;
            r_stop_bit_size <= 1'b0;
            r_shift         <= 8'h00;
            r_bit_cnt       <= 3'd0;
            r_par_err       <= 1'b0;
            r_frm_err       <= 1'b0;
            r_data          <= 8'h00;
            r_err_crc       <= 1'b0;
            r_err_frame     <= 1'b0;
            r_ready         <= 1'b1;
            r_new_data      <= 1'b0;
        end else begin
            r_new_data <= 1'b0;
            case (r_state)
                S_IDLE: if (w_fall) begin
                    r_period        <= w_period_in;
                    r_data_size     <= data_size;
                    r_parity_en     <= parity_en;
                    r_parity_mode   <= parity_mode;
                    r_stop_bit_size <= stop_bit_size;
                    r_shift         <= 8'h00;
                    r_bit_cnt       <= 3'd0;
                    r_par_err       <= 1'b0;
                    r_frm_err       <= 1'b0;
                    r_ready         <= 1'b0;
                    r_state         <= S_START;
                end
                S_START: if (w_tick) begin
                    if (r_rx_sync) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: if (w_tick) begin
                    r_shift   <= {r_rx_sync, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_last_bit)
                        r_state <= r_parity_en ? S_PARITY : S_STOP;
                end
                S_PARITY: if (w_tick) begin
                    r_par_err <= (r_rx_sync != w_par_exp);
                    r_state   <= S_STOP;
                end
                S_STOP: if (w_tick) begin
                    r_frm_err <= ~r_rx_sync;
                    r_state   <= r_stop_bit_size ? S_STOP2 : S_DONE;
                end
                S_STOP2: if (w_tick) begin
                    r_frm_err <= r_frm_err | ~r_rx_sync;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_data      <= w_word;
                    r_err_crc   <= r_par_err;
                    r_err_frame <= r_frm_err;
                    r_new_data  <= 1'b1;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data      = r_data;
    assign err_crc   = r_err_crc;
    assign err_frame = r_err_frame;
    assign ready     = r_ready;
    assign new_data  = r_new_data;
endmodule

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_unit: frames are driven serially, expected
// results queued at send time and compared when new_data pulses.
module tb_uart_rx_unit;
    logic       clk = 1'b0;
    logic       rst, rx, baud_sel, data_size, parity_en, stop_bit_size;
    logic [2:0] div_ratio;
    logic [1:0] parity_mode;
    logic [7:0] data;
    logic       err_crc, err_frame, ready, new_data;

    uart_rx_unit #(.CLK_HZ(100_000_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_sel(baud_sel), .div_ratio(div_ratio),
        .data_size(data_size), .parity_en(parity_en), .parity_mode(parity_mode),
        .stop_bit_size(stop_bit_size), .data(data), .err_crc(err_crc),
        .err_frame(err_frame), .ready(ready), .new_data(new_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       crc;
        logic       frm;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] last_data = 8'h00;

    localparam int FAST_NS = 2160;
    localparam int SLOW_NS = 26040;

    function automatic logic ref_parity(input logic [7:0] d, input int nbits, input logic [1:0] mode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        case (mode)
            2'b11:   return (ones % 2) == 0;
            2'b10:   return (ones % 2) == 1;
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_cfg(input logic bs, input logic [2:0] dv, input logic ds,
                           input logic pe, input logic [1:0] pm, input logic sb2);
        baud_sel = bs; div_ratio = dv; data_size = ds;
        parity_en = pe; parity_mode = pm; stop_bit_size = sb2;
    endtask

    task automatic send_frame(input int bit_ns, input logic [7:0] d, input int nbits, input bit pe,
                              input logic pbit, input int nstop, input logic s1, input logic s2,
                              input bit scramble);
        logic       o_bs, o_ds, o_sb;
        logic [1:0] o_pm;
        logic [2:0] o_dv;
        o_bs = baud_sel; o_ds = data_size; o_sb = stop_bit_size; o_pm = parity_mode; o_dv = div_ratio;
        rx = 1'b0;
        #(bit_ns);
        if (scramble) begin
            baud_sel = ~o_bs; data_size = ~o_ds; stop_bit_size = ~o_sb;
            parity_mode = ~o_pm; div_ratio = o_dv + 3'd1;
        end
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        if (pe) begin
            rx = pbit;
            #(bit_ns);
        end
        rx = s1;
        #(bit_ns);
        if (nstop == 2) begin
            rx = s2;
            #(bit_ns);
        end
        baud_sel = o_bs; data_size = o_ds; stop_bit_size = o_sb; parity_mode = o_pm; div_ratio = o_dv;
        rx = 1'b1;
        #(2 * bit_ns);
    endtask

    // Queues the expected result, drives the frame and checks the DUT response.
    task automatic run_frame(input int bit_ns, input logic [7:0] d, input logic pbit,
                             input logic s1, input logic s2, input bit scramble, input string name);
        exp_t e, got_e;
        int   nbits, nstop, budget;
        bit   pe, got;
        nbits = data_size ? 8 : 7;
        nstop = stop_bit_size ? 2 : 1;
        pe    = parity_en;
        e.d   = (nbits == 7) ? {1'b0, d[6:0]} : d;
        e.crc = pe && (pbit != ref_parity(d, nbits, parity_mode));
        e.frm = !s1 || (nstop == 2 && !s2);
        sb.push_back(e);
        budget = (bit_ns / 10) * (nbits + 5) + 100;
        got = 0;
        fork
            send_frame(bit_ns, d, nbits, pe, pbit, nstop, s1, s2, scramble);
            begin
                for (int i = 0; i < budget; i++) begin
                    @(negedge clk);
                    if (new_data) begin
                        got = 1;
                        break;
                    end
                end
                vectors++;
                got_e = sb.pop_front();
                if (!got) begin
                    $display("FAIL %s timeout: new_data not seen within %0d cycles", name, budget);
                    miscompares++;
                end else begin
                    last_data = got_e.d;
                    $display("%s: data=%02h crc=%0b frm=%0b (want %02h %0b %0b)",
                             name, data, err_crc, err_frame, got_e.d, got_e.crc, got_e.frm);
                    if ({data, err_crc, err_frame} !== got_e) begin
                        $display("FAIL %s result: got data=%02h crc=%0b frm=%0b, want data=%02h crc=%0b frm=%0b",
                                 name, data, err_crc, err_frame, got_e.d, got_e.crc, got_e.frm);
                        miscompares++;
                    end
                    vectors++;
                    if (ready !== 1'b1) begin
                        $display("FAIL %s ready_at_done: got %b want 1", name, ready);
                        miscompares++;
                    end
                    @(negedge clk);
                    vectors++;
                    if (new_data !== 1'b0) begin
                        $display("FAIL %s pulse_width: new_data got %b want 0 on second cycle", name, new_data);
                        miscompares++;
                    end
                end
            end
        join
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b1, 2'b01, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ready, new_data, data, err_crc, err_frame} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: got ready=%b new=%b data=%02h crc=%b frm=%b want 1 0 00 0 0",
                     ready, new_data, data, err_crc, err_frame);
            miscompares++;
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || new_data !== 1'b0) begin
            $display("FAIL post_reset_idle: got ready=%b new=%b want 1 0", ready, new_data);
            miscompares++;
        end
        $display("reset: ready=%b data=%02h", ready, data);
    endtask

    task automatic test_mark_parity;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b1, 2'b01, 1'b0);
        run_frame(FAST_NS, 8'h95, 1'b1, 1'b1, 1'b1, 1'b1, "mark_clean_scrambled_cfg");
        run_frame(FAST_NS, 8'h95, 1'b0, 1'b1, 1'b1, 1'b0, "mark_bad_parity");
    endtask

    task automatic test_framing;
        set_cfg(1'b1, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        run_frame(FAST_NS, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, "7bit_framing_err");
        run_frame(FAST_NS, 8'hEA, 1'b0, 1'b1, 1'b1, 1'b0, "7bit_clean");
    endtask

    task automatic test_even_odd;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b1, 2'b10, 1'b0);
        run_frame(FAST_NS, 8'h95, 1'b0, 1'b1, 1'b1, 1'b0, "even_ok");
        run_frame(FAST_NS, 8'h95, 1'b1, 1'b1, 1'b1, 1'b0, "even_bad");
        parity_mode = 2'b11;
        run_frame(FAST_NS, 8'h95, 1'b1, 1'b1, 1'b1, 1'b0, "odd_ok");
        run_frame(FAST_NS, 8'h95, 1'b0, 1'b1, 1'b1, 1'b0, "odd_bad");
        parity_mode = 2'b00;
        run_frame(FAST_NS, 8'h95, 1'b1, 1'b1, 1'b1, 1'b0, "space_bad");
    endtask

    task automatic test_stop2_and_slow;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1);
        run_frame(FAST_NS, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, "stop2_second_zero");
        run_frame(FAST_NS, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, "stop2_clean");
        set_cfg(1'b0, 3'd1, 1'b1, 1'b0, 2'b00, 1'b0);
        run_frame(SLOW_NS, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, "slow_div1_clean");
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic [1:0] pm;
        logic       pb;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b1, 2'b11, 1'b0);
        for (int k = 0; k < 4; k++) begin
            d  = 8'($urandom_range(0, 255));
            pm = 2'($urandom_range(0, 3));
            pb = 1'($urandom_range(0, 1));
            parity_mode = pm;
            run_frame(FAST_NS, d, pb, 1'b1, 1'b1, 1'b0, $sformatf("b2b_%0d", k));
        end
    endtask

    task automatic test_glitch;
        bit seen;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        rx = 1'b0;
        #500;
        rx = 1'b1;
        seen = 0;
        repeat (3 * 217) begin
            @(negedge clk);
            if (new_data) seen = 1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            $display("FAIL glitch_no_new_data: got pulse want none");
            miscompares++;
        end
        vectors++;
        if (ready !== 1'b1 || data !== last_data) begin
            $display("FAIL glitch_state: got ready=%b data=%02h want ready=1 data=%02h", ready, data, last_data);
            miscompares++;
        end
        $display("glitch: ready=%b data=%02h", ready, data);
    endtask

    task automatic test_reset_midframe;
        bit seen;
        set_cfg(1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        rx = 1'b0; #(FAST_NS);
        rx = 1'b1; #(FAST_NS);
        rx = 1'b0; #(FAST_NS);
        @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({ready, new_data, data, err_crc, err_frame} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL midframe_reset: got ready=%b new=%b data=%02h crc=%b frm=%b want 1 0 00 0 0",
                     ready, new_data, data, err_crc, err_frame);
            miscompares++;
        end
        last_data = 8'h00;
        seen = 0;
        repeat (10 * 217) begin
            @(negedge clk);
            if (new_data || !ready) seen = 1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            $display("FAIL midframe_reset_idle: receiver left idle after reset");
            miscompares++;
        end
        $display("reset_midframe: ready=%b data=%02h", ready, data);
        run_frame(FAST_NS, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, "after_reset_clean");
    endtask

    initial begin
        test_reset();
        test_mark_parity();
        test_framing();
        test_even_odd();
        test_stop2_and_slow();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
